piano_key_ctrl: RTL and testbench

PIANO_KEY_CTRL -- requirements
Module: piano_key_ctrl

---
 rtl/piano_pkg.sv | 27 ++
 rtl/piano_debounce.sv | 53 +++++
 rtl/piano_key_ctrl.sv | 104 ++++++++++
 tb/tb_piano_key_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared limits, reset defaults and saturating step helper for the piano front end.
// Latency: none (constants and a combinational function). Backpressure: none.
package piano_pkg;

    localparam int OCT_MAX      = 7;
    localparam int VOL_MAX      = 15;
    localparam int OCT_INIT_DEF = 3;
    localparam int VOL_INIT_DEF = 8;

    // Opposing steps in the same cycle cancel; never wraps past 0 or max_v.
    function automatic logic [3:0] sat_step(
        input logic [3:0] cur,
        input logic       up,
        input logic       dn,
        input logic [3:0] max_v
    );
        logic [3:0] nxt;
        nxt = cur;
        if (up && !dn && (cur < max_v)) begin
            nxt = cur + 4'd1;
        end else if (dn && !up && (cur != 4'd0)) begin
            nxt = cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/piano_debounce.sv
// Single-bit 2-flop synchronizer followed by a stable-state debouncer.
// Latency: a steady raw edge appears on dout 2+DEBOUNCE_CLKS clocks later. Backpressure: none.
module piano_debounce #(
    parameter int DEBOUNCE_CLKS = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int            CW       = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // Any cycle agreeing with the stable state restarts the count, so glitches never accumulate.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/piano_key_ctrl.sv
// Piano key/button front end: debounced key gates, octave and volume steppers; PIANO_SUSTAIN_EN adds pedal sustain.
// Latency: outputs update 1 clock after the debounced change. Backpressure: none.
module piano_key_ctrl
    import piano_pkg::*;
#(
    parameter int NUM_KEYS      = 12,
    parameter int DEBOUNCE_CLKS = 1000000,
    parameter int OCT_INIT      = OCT_INIT_DEF,
    parameter int VOL_INIT      = VOL_INIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                btn_oct_up,
    input  logic                btn_oct_dn,
    input  logic                btn_vol_up,
    input  logic                btn_vol_dn,
    input  logic                sustain_pedal,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [2:0]          octave,
    output logic [3:0]          volume,
    output logic                key_event
);

    logic [NUM_KEYS-1:0] keys_db;
    logic [3:0]          btn_raw;
    logic [3:0]          btn_db;
    logic                pedal_db;

    // Bit order: oct_up, oct_dn, vol_up, vol_dn.
    assign btn_raw = {btn_vol_dn, btn_vol_up, btn_oct_dn, btn_oct_up};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        piano_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (keys_raw[i]),
            .dout  (keys_db[i])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        piano_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (btn_raw[i]),
            .dout  (btn_db[i])
        );
    end

`ifdef PIANO_SUSTAIN_EN
    piano_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_pedal_db (
        .clk   (clk),
        .reset (reset),
        .din   (sustain_pedal),
        .dout  (pedal_db)
    );
`else
    logic unused_pedal;
    assign unused_pedal = sustain_pedal;
    assign pedal_db     = 1'b0;
`endif

    logic [3:0]          btn_db_q, btn_db_d;
    logic [3:0]          btn_rise;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic                key_event_q, key_event_d;
    logic [2:0]          octave_q, octave_d;
    logic [3:0]          volume_q, volume_d;
    logic [3:0]          oct_step;

    always_comb begin
        btn_db_d = btn_db;
        btn_rise = btn_db & ~btn_db_q;
        oct_step = sat_step({1'b0, octave_q}, btn_rise[0], btn_rise[1], 4'(OCT_MAX));
        octave_d = oct_step[2:0];
        volume_d = sat_step(volume_q, btn_rise[2], btn_rise[3], 4'(VOL_MAX));
        // Held pedal latches presses; releases only take effect once the pedal lifts.
        key_press_d = pedal_db ? (key_press_q | keys_db) : keys_db;
        key_event_d = |(key_press_d & ~key_press_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db_q    <= '0;
            key_press_q <= '0;
            key_event_q <= 1'b0;
            octave_q    <= 3'(OCT_INIT);
            volume_q    <= 4'(VOL_INIT);
        end else begin
            btn_db_q    <= btn_db_d;
            key_press_q <= key_press_d;
            key_event_q <= key_event_d;
            octave_q    <= octave_d;
            volume_q    <= volume_d;
        end
    end

    assign key_press = key_press_q;
    assign key_event = key_event_q;
    assign octave    = octave_q;
    assign volume    = volume_q;

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Self-checking bench for piano_key_ctrl with DEBOUNCE_CLKS=4: directed table, corner sequences, random vs model.
module tb_piano_key_ctrl;

    localparam int D  = 4;
    localparam int NK = 12;
    localparam int NI = 17;  // keys[11:0], oct_up, oct_dn, vol_up, vol_dn, pedal

    logic          clk;
    logic          reset;
    logic [NI-1:0] raw;
    logic [NK-1:0] key_press;
    logic [2:0]    octave;
    logic [3:0]    volume;
    logic          key_event;

    piano_key_ctrl #(.NUM_KEYS(NK), .DEBOUNCE_CLKS(D), .OCT_INIT(3), .VOL_INIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_raw      (raw[11:0]),
        .btn_oct_up    (raw[12]),
        .btn_oct_dn    (raw[13]),
        .btn_vol_up    (raw[14]),
        .btn_vol_dn    (raw[15]),
        .sustain_pedal (raw[16]),
        .key_press     (key_press),
        .octave        (octave),
        .volume        (volume),
        .key_event     (key_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_seen = 0;

    // Reference model: an input's debounced value flips once its last D synchronized samples all disagree.
    logic [NI-1:0] m_h [0:D+1];
    logic [NI-1:0] m_db, m_dbp;
    logic [NK-1:0] m_kp;
    logic          m_ev;
    int            m_oct, m_vol;

    task automatic model_reset();
        for (int i = 0; i <= D + 1; i++) m_h[i] = '0;
        m_db = '0; m_dbp = '0; m_kp = '0; m_ev = 1'b0;
        m_oct = 3; m_vol = 8;
    endtask

    task automatic model_step();
        logic [NI-1:0] dbm1, dbn, rise;
        logic [NK-1:0] kpn;
        logic          all_opp;
        for (int i = D + 1; i >= 1; i--) m_h[i] = m_h[i-1];
        m_h[0] = raw;
        dbm1 = m_db;
        for (int b = 0; b < NI; b++) begin
            all_opp = 1'b1;
            for (int i = 2; i <= D + 1; i++) if (m_h[i][b] == dbm1[b]) all_opp = 1'b0;
            dbn[b] = all_opp ? ~dbm1[b] : dbm1[b];
        end
        rise = dbm1 & ~m_dbp;
        if (rise[12] && !rise[13]) m_oct = (m_oct < 7) ? m_oct + 1 : 7;
        else if (rise[13] && !rise[12]) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
        if (rise[14] && !rise[15]) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
        else if (rise[15] && !rise[14]) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
`ifdef PIANO_SUSTAIN_EN
        kpn = dbm1[16] ? (m_kp | dbm1[11:0]) : dbm1[11:0];
`else
        kpn = dbm1[11:0];
`endif
        m_ev  = |(kpn & ~m_kp);
        m_kp  = kpn;
        m_dbp = dbm1;
        m_db  = dbn;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        if (key_event === 1'b1) ev_seen++;
        check("model", {12'(key_press), 1'(key_event), 3'(octave), 4'(volume)},
              {m_kp, m_ev, 3'(m_oct), 4'(m_vol)});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        run(2);
        reset = 1'b0;
    endtask

    task automatic press(input int bit_i);
        raw[bit_i] = 1'b1;
        run(8);
        raw[bit_i] = 1'b0;
        run(8);
    endtask

    typedef struct {
        logic [NK-1:0] keys;
        int            hold;
        logic [NK-1:0] exp_kp;
        int            exp_ev;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int exp_v;
        tbl[0] = '{12'h001, 10, 12'h001, 1};
        tbl[1] = '{12'h003, 10, 12'h003, 1};
        tbl[2] = '{12'h002, 10, 12'h002, 0};
        tbl[3] = '{12'hF00, 10, 12'hF00, 1};
        tbl[4] = '{12'hF20,  2, 12'hF00, 0};
        tbl[5] = '{12'hF00, 10, 12'hF00, 0};
        tbl[6] = '{12'h000, 10, 12'h000, 0};
        tbl[7] = '{12'hFFF,  5, 12'h000, 0};
        tbl[8] = '{12'hFFF,  5, 12'hFFF, 1};
        tbl[9] = '{12'h000, 10, 12'h000, 0};

        reset = 1'b1;
        raw   = '0;
        model_reset();
        @(negedge clk);
        check("rst_kp",  32'(key_press), 32'h0);
        check("rst_ev",  32'(key_event), 32'h0);
        check("rst_oct", 32'(octave),    32'd3);
        check("rst_vol", 32'(volume),    32'd8);
        reset = 1'b0;
        run(2);

        // Key 0 held: gate and event exactly 7 clocks after the edge.
        raw[0] = 1'b1;
        run(6);
        check("k0_early", 32'(key_press), 32'h0);
        run(1);
        check("k0_kp", 32'(key_press), 32'h1);
        check("k0_ev", 32'(key_event), 32'h1);
        run(1);
        check("k0_ev_once", 32'(key_event), 32'h0);
        raw[0] = 1'b0;
        run(10);

        // Key 5 high for 2 clocks never gets through.
        ev_seen = 0;
        raw[5] = 1'b1;
        run(2);
        raw[5] = 1'b0;
        run(12);
        check("glitch_kp", 32'(key_press), 32'h0);
        check("glitch_ev", 32'(ev_seen),   32'd0);

        for (int i = 0; i < 10; i++) begin
            ev_seen = 0;
            raw[11:0] = tbl[i].keys;
            run(tbl[i].hold);
            check($sformatf("tbl%0d_kp", i), 32'(key_press), 32'(tbl[i].exp_kp));
            check($sformatf("tbl%0d_ev", i), 32'(ev_seen),   32'(tbl[i].exp_ev));
        end

        do_reset();
        exp_v = 3;
        for (int i = 0; i < 9; i++) begin
            press(12);
            exp_v = (exp_v < 7) ? exp_v + 1 : 7;
            check($sformatf("oct_up%0d", i), 32'(octave), 32'(exp_v));
        end
        for (int i = 0; i < 9; i++) begin
            press(13);
            exp_v = (exp_v > 0) ? exp_v - 1 : 0;
            check($sformatf("oct_dn%0d", i), 32'(octave), 32'(exp_v));
        end
        raw[15] = 1'b1;
        run(100);
        check("vol_dn_held", 32'(volume), 32'd7);
        raw[15] = 1'b0;
        run(8);
        exp_v = 7;
        for (int i = 0; i < 10; i++) begin
            press(14);
            exp_v = (exp_v < 15) ? exp_v + 1 : 15;
            check($sformatf("vol_up%0d", i), 32'(volume), 32'(exp_v));
        end

        do_reset();
        raw[14] = 1'b1;
        raw[15] = 1'b1;
        run(12);
        check("vol_both", 32'(volume), 32'd8);
        raw[14] = 1'b0;
        raw[15] = 1'b0;
        run(10);
        check("vol_both_rel", 32'(volume), 32'd8);

        do_reset();
`ifdef PIANO_SUSTAIN_EN
        raw[16] = 1'b1;
        run(8);
        raw[2] = 1'b1;
        run(10);
        check("sus_on", 32'(key_press[2]), 32'h1);
        raw[2] = 1'b0;
        run(10);
        check("sus_hold", 32'(key_press[2]), 32'h1);
        raw[16] = 1'b0;
        run(6);
        check("sus_lift_early", 32'(key_press[2]), 32'h1);
        run(1);
        check("sus_lift", 32'(key_press[2]), 32'h0);
`else
        raw[16] = 1'b1;
        run(8);
        raw[2] = 1'b1;
        run(10);
        check("nosus_on", 32'(key_press[2]), 32'h1);
        raw[2] = 1'b0;
        run(10);
        check("nosus_off", 32'(key_press[2]), 32'h0);
        raw[16] = 1'b0;
        run(8);
`endif

        // Asynchronous reset from a busy state, checked before any clock edge.
        do_reset();
        for (int i = 0; i < 3; i++) press(12);
        for (int i = 0; i < 4; i++) press(14);
        raw[11:0] = 12'h081;
        run(10);
        check("pre_oct", 32'(octave),    32'd6);
        check("pre_vol", 32'(volume),    32'd12);
        check("pre_kp",  32'(key_press), 32'h081);
        #1 reset = 1'b1;
        #1;
        check("arst_oct", 32'(octave),    32'd3);
        check("arst_vol", 32'(volume),    32'd8);
        check("arst_kp",  32'(key_press), 32'h0);
        check("arst_ev",  32'(key_event), 32'h0);
        model_reset();
        run(2);
        reset = 1'b0;
        run(10);

        for (int s = 0; s < 400; s++) begin
            raw[11:0] = raw[11:0] ^ 12'($urandom & $urandom & $urandom);
            for (int b = 12; b < 16; b++) raw[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) raw[16] = ~raw[16];
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                model_reset();
                run(2);
                reset = 1'b0;
            end
            run($urandom_range(1, 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
